// File: rtl/sram_1p_be_ctrl.sv
// Single-port SRAM with per-bit write enables, req/gnt/rvalid handshake,
// 1- or 2-cycle read latency and a zero-initialisation sweep sequencer.
module sram_1p_be_ctrl #(
    parameter int unsigned Width       = 76,
    parameter int unsigned Depth       = 4096,
    parameter int unsigned AddrW       = $clog2(Depth),
    parameter int unsigned ReadLat     = 1,
    parameter bit          InitOnReset = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Width-1:0] wmask_i,
    output logic             gnt_o,
    output logic             rvalid_o,
    output logic [Width-1:0] rdata_o,
    output logic             rerror_o,
    input  logic             init_req_i,
    output logic             init_done_o
);

    typedef enum logic [1:0] {INIT, READY, DRAIN} state_t;

    localparam logic [AddrW:0]   DEPTH_EXT = (AddrW + 1)'(Depth);
    localparam logic [AddrW-1:0] LAST_ADDR = AddrW'(Depth - 1);

    logic [Width-1:0] mem [Depth];

    state_t           state_q, state_d;
    logic [AddrW-1:0] cnt_q, cnt_d;
    logic             in_range;
    logic             rd_gnt;
    logic             wr_gnt;
    logic             inflight;

    logic             vld_p0;
    logic             err_p0;
    logic [Width-1:0] dat_p0;

    assign in_range    = ({1'b0, addr_i} < DEPTH_EXT);
    assign init_done_o = (state_q == READY);
    assign gnt_o       = req_i && (state_q == READY);
    assign rd_gnt      = gnt_o && !we_i;
    assign wr_gnt      = gnt_o && we_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= InitOnReset ? INIT : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A read granted in the same cycle as init_req_i still has to return, so it forces DRAIN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + AddrW'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                if (init_req_i) begin
                    state_d = (rd_gnt || inflight) ? DRAIN : INIT;
                end
            end
            DRAIN: begin
                if (!inflight) begin
                    state_d = INIT;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Storage has no reset: only the sweep or a granted write changes it.
    always_ff @(posedge clk_i) begin
        if (state_q == INIT) begin
            mem[cnt_q] <= '0;
        end else if (wr_gnt && in_range) begin
            mem[addr_i] <= (mem[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
        end
    end

    // ---- stage p0: array read at grant ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p0 <= 1'b0;
            dat_p0 <= '0;
            err_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_gnt;
            if (rd_gnt) begin
                dat_p0 <= in_range ? mem[addr_i] : '0;
                err_p0 <= !in_range;
            end
        end
    end

    // A read whose rvalid_o is showing this cycle has completed; only earlier stages are in flight.
    if (ReadLat == 1) begin : g_lat1
        assign inflight = 1'b0;
        assign rvalid_o = vld_p0;
        assign rdata_o  = dat_p0;
        assign rerror_o = err_p0;
    end else begin : g_lat2
        logic             vld_p1;
        logic             err_p1;
        logic [Width-1:0] dat_p1;

        // ---- stage p1: extra output register ----
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_p1 <= 1'b0;
                dat_p1 <= '0;
                err_p1 <= 1'b0;
            end else begin
                vld_p1 <= vld_p0;
                if (vld_p0) begin
                    dat_p1 <= dat_p0;
                    err_p1 <= err_p0;
                end
            end
        end

        assign inflight = vld_p0;
        assign rvalid_o = vld_p1;
        assign rdata_o  = dat_p1;
        assign rerror_o = err_p1;
    end

endmodule

// File: tb/tb_sram_1p_be_ctrl.sv
// Bench for sram_1p_be_ctrl: two instances (Depth 3000/ReadLat 1, Depth 4096/ReadLat 2)
// driven cycle by cycle and compared against an array model with an expected-read queue.
module tb_sram_1p_be_ctrl;

    localparam int W  = 76;
    localparam int D0 = 3000;
    localparam int D1 = 4096;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req [2];
    logic           we [2];
    logic [11:0]    addr [2];
    logic [W-1:0]   wdata [2];
    logic [W-1:0]   wmask [2];
    logic           init_req [2];
    logic           gnt [2];
    logic           rvalid [2];
    logic [W-1:0]   rdata [2];
    logic           rerror [2];
    logic           init_done [2];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int dep [2] = '{D0, D1};
    int lat [2] = '{1, 2};
    int ready_at [2];
    logic [W-1:0] mdl [2][4096];

    typedef struct {
        int           d;
        int           due;
        logic [W-1:0] data;
        logic         err;
    } rd_t;
    rd_t pq[$];

    sram_1p_be_ctrl #(.Width(W), .Depth(D0), .ReadLat(1), .InitOnReset(1'b1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .wmask_i(wmask[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .rerror_o(rerror[0]), .init_req_i(init_req[0]),
        .init_done_o(init_done[0])
    );

    sram_1p_be_ctrl #(.Width(W), .Depth(D1), .ReadLat(2), .InitOnReset(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .wmask_i(wmask[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .rerror_o(rerror[1]), .init_req_i(init_req[1]),
        .init_done_o(init_done[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL timeout: cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] rnd_word();
        return W'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic wipe(input int d);
        for (int i = 0; i < 4096; i++) mdl[d][i] = '0;
    endtask

    // One clock cycle of traffic on instance d, checking rvalid/data, init_done and gnt.
    task automatic step(input int d, input bit rq, input bit wr, input int a,
                        input logic [W-1:0] wd, input logic [W-1:0] wm, input bit ir);
        int c, idx, last;
        bit rdy, exp_v, exp_g;
        rd_t e;
        @(negedge clk);
        c = cyc;
        idx = -1;
        foreach (pq[i]) if (idx < 0 && pq[i].d == d) idx = i;
        if (idx >= 0 && pq[idx].due < c) begin
            checks++; errors++;
            $display("FAIL missing_rvalid d%0d: due %0d, now %0d", d, pq[idx].due, c);
            pq.delete(idx);
            idx = -1;
            foreach (pq[i]) if (idx < 0 && pq[i].d == d) idx = i;
        end
        exp_v = (idx >= 0) && (pq[idx].due == c);
        checks++;
        if (rvalid[d] !== exp_v) begin
            errors++;
            $display("FAIL rvalid d%0d cyc %0d: got %b want %b", d, c, rvalid[d], exp_v);
        end
        if (exp_v) begin
            checks++;
            if (rdata[d] !== pq[idx].data || rerror[d] !== pq[idx].err) begin
                errors++;
                $display("FAIL rdata d%0d cyc %0d: got %h/%b want %h/%b", d, c,
                         rdata[d], rerror[d], pq[idx].data, pq[idx].err);
            end
            pq.delete(idx);
        end
        rdy = (c >= ready_at[d]);
        checks++;
        if (init_done[d] !== rdy) begin
            errors++;
            $display("FAIL init_done d%0d cyc %0d: got %b want %b", d, c, init_done[d], rdy);
        end
        req[d] = rq; we[d] = wr; addr[d] = 12'(a);
        wdata[d] = wd; wmask[d] = wm; init_req[d] = ir;
        #1;
        exp_g = rq && rdy;
        checks++;
        if (gnt[d] !== exp_g) begin
            errors++;
            $display("FAIL gnt d%0d cyc %0d: got %b want %b", d, c, gnt[d], exp_g);
        end
        if (exp_g) begin
            if (wr) begin
                if (a < dep[d]) mdl[d][a] = (mdl[d][a] & ~wm) | (wd & wm);
            end else begin
                e.d = d;
                e.due = c + lat[d];
                e.err = (a >= dep[d]);
                e.data = (a < dep[d]) ? mdl[d][a] : '0;
                pq.push_back(e);
            end
        end
        if (ir && rdy) begin
            last = -1;
            foreach (pq[i]) if (pq[i].d == d && pq[i].due > last) last = pq[i].due;
            ready_at[d] = (last >= 0) ? last + 1 + dep[d] : c + 1 + dep[d];
            wipe(d);
        end
    endtask

    task automatic flush(input int d);
        repeat (4) step(d, 1'b0, 1'b0, 0, '0, '0, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pq.delete();
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b1; we[d] = 1'b0; addr[d] = '0; init_req[d] = 1'b0;
            wdata[d] = '0; wmask[d] = '0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (gnt[d] !== 1'b0 || rvalid[d] !== 1'b0 || rdata[d] !== '0 ||
                rerror[d] !== 1'b0 || init_done[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_values d%0d: gnt %b rvalid %b rdata %h rerror %b done %b, want all 0",
                         d, gnt[d], rvalid[d], rdata[d], rerror[d], init_done[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ready_at[d] = cyc + dep[d];
            wipe(d);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (gnt[d] !== 1'b0) begin
                errors++;
                $display("FAIL gnt_after_release d%0d: got %b want 0", d, gnt[d]);
            end
            req[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_init_sweep(input int d);
        while (cyc < ready_at[d]) step(d, 1'b1, 1'b0, $urandom_range(0, dep[d] - 1), '0, '0, 1'b0);
        step(d, 1'b1, 1'b0, 0, '0, '0, 1'b0);
        step(d, 1'b1, 1'b0, dep[d] / 2, '0, '0, 1'b0);
        step(d, 1'b1, 1'b0, dep[d] - 1, '0, '0, 1'b0);
        flush(d);
        checks++;
        if (rdata[d] !== '0 || init_done[d] !== 1'b1) begin
            errors++;
            $display("FAIL init_sweep d%0d: rdata %h done %b, want 0/1", d, rdata[d], init_done[d]);
        end
    endtask

    task automatic test_partial_write();
        step(0, 1'b1, 1'b1, 5, '1, 76'hFF00, 1'b0);
        step(0, 1'b1, 1'b0, 5, '0, '0, 1'b0);
        flush(0);
        checks++;
        if (rdata[0] !== 76'hFF00 || rerror[0] !== 1'b0) begin
            errors++;
            $display("FAIL partial_write: rdata %h, want %h", rdata[0], 76'hFF00);
        end
    endtask

    task automatic test_raw();
        step(0, 1'b1, 1'b1, 7, 76'hA5, '1, 1'b0);
        step(0, 1'b1, 1'b0, 7, '0, '0, 1'b0);
        flush(0);
        checks++;
        if (rdata[0] !== 76'hA5) begin
            errors++;
            $display("FAIL read_after_write: rdata %h, want a5", rdata[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v3;
        v3 = rnd_word();
        step(1, 1'b1, 1'b1, 1, rnd_word(), '1, 1'b0);
        step(1, 1'b1, 1'b1, 2, rnd_word(), '1, 1'b0);
        step(1, 1'b1, 1'b1, 3, v3, '1, 1'b0);
        for (int i = 1; i <= 3; i++) step(1, 1'b1, 1'b0, i, '0, '0, 1'b0);
        flush(1);
        checks++;
        if (rdata[1] !== v3) begin
            errors++;
            $display("FAIL back_to_back_last: rdata %h, want %h", rdata[1], v3);
        end
    endtask

    task automatic test_random(input int d, input int n);
        int r;
        logic [W-1:0] m;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0: m = '0;
                1: m = '1;
                default: m = rnd_word();
            endcase
            if (r < 2) step(d, 1'b0, 1'b0, 0, '0, '0, 1'b0);
            else step(d, 1'b1, r < 6, $urandom_range(0, 4095), rnd_word(), m, 1'b0);
        end
        flush(d);
    endtask

    task automatic test_out_of_range();
        step(0, 1'b1, 1'b0, 3500, '0, '0, 1'b0);
        flush(0);
        checks++;
        if (rdata[0] !== '0 || rerror[0] !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: rdata %h rerror %b, want 0/1", rdata[0], rerror[0]);
        end
        step(0, 1'b1, 1'b1, 3500, rnd_word(), '1, 1'b0);
        for (int i = 0; i < D0; i++) step(0, 1'b1, 1'b0, i, '0, '0, 1'b0);
        flush(0);
    endtask

    task automatic test_init_drain(input int d);
        step(d, 1'b1, 1'b1, 9, rnd_word(), '1, 1'b0);
        if (lat[d] == 2) step(d, 1'b1, 1'b0, 9, '0, '0, 1'b0);
        step(d, 1'b1, 1'b0, 9, '0, '0, 1'b1);
        while (cyc < ready_at[d])
            step(d, 1'b1, $urandom_range(0, 1), $urandom_range(0, dep[d] - 1), '1, '1, $urandom_range(0, 1));
        if (d == 0) begin
            for (int i = 0; i < D0; i++) step(0, 1'b1, 1'b0, i, '0, '0, 1'b0);
        end else begin
            for (int i = 0; i < 40; i++) step(d, 1'b1, 1'b0, $urandom_range(0, dep[d] - 1), '0, '0, 1'b0);
        end
        flush(d);
    endtask

    task automatic test_init_idle();
        step(1, 1'b1, 1'b1, 11, rnd_word(), '1, 1'b0);
        flush(1);
        step(1, 1'b0, 1'b0, 0, '0, '0, 1'b1);
        while (cyc < ready_at[1]) step(1, 1'b1, 1'b0, 11, '0, '0, $urandom_range(0, 1));
        step(1, 1'b1, 1'b0, 11, '0, '0, 1'b0);
        flush(1);
        checks++;
        if (rdata[1] !== '0) begin
            errors++;
            $display("FAIL init_idle_clear: rdata %h, want 0", rdata[1]);
        end
    endtask

    task automatic test_reset_midflight();
        step(1, 1'b1, 1'b1, 20, rnd_word(), '1, 1'b0);
        step(1, 1'b1, 1'b0, 20, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        pq.delete();
        req[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (rvalid[1] !== 1'b0 || rvalid[0] !== 1'b0) begin
                errors++;
                $display("FAIL midflight_rvalid: got %b/%b want 0/0", rvalid[0], rvalid[1]);
            end
        end
        apply_reset();
        test_init_sweep(1);
        test_init_sweep(0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; init_req[d] = 1'b0;
            wdata[d] = '0; wmask[d] = '0; ready_at[d] = 0;
        end
        test_reset();
        test_init_sweep(0);
        test_init_sweep(1);
        test_partial_write();
        test_raw();
        test_back_to_back();
        test_random(0, 300);
        test_random(1, 300);
        test_out_of_range();
        test_init_drain(0);
        test_init_drain(1);
        test_init_idle();
        test_reset_midflight();
        flush(0);
        flush(1);
        checks++;
        if (pq.size() != 0) begin
            errors++;
            $display("FAIL leftover_reads: %0d outstanding, want 0", pq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
